// File: rtl/nic_host_sched.sv
// Host-side NIC port scheduler: polls the NIC receive path and services
// round-robin transmit requesters over a single registered CPU port.
module nic_host_sched #(
    parameter int PACKET_WIDTH = 64,
    parameter int NUM_REQ      = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_tx,
    input  logic [NUM_REQ*PACKET_WIDTH-1:0] req_tx_data,
    output logic [NUM_REQ-1:0]              tx_done,
    output logic                            rx_valid,
    output logic [PACKET_WIDTH-1:0]         rx_data,
    input  logic                            rx_ready,
    output logic [1:0]                      nic_addr,
    output logic [PACKET_WIDTH-1:0]         nic_d_in,
    output logic                            nic_en,
    output logic                            nic_en_wr,
    input  logic [PACKET_WIDTH-1:0]         nic_d_out,
    output logic                            busy
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        IDLE, RX_STAT, RX_STAT_W, RX_READ,
        RX_READ_W, TX_STAT, TX_STAT_W, TX_WRITE
    } state_t;

    state_t state, state_nx;

    logic [IW-1:0] ptr, ptr_nx, grant, pick, done_idx;
    logic          turn_tx, found, any_req, grant_req;
    logic          start_tx, zero_done, write_done, adv_ptr;
    logic          capture, turn_set_tx, turn_set_rx;
    logic [PACKET_WIDTH-1:0] pick_data, grant_data, din_nx;
    logic [NUM_REQ-1:0]      done_nx;
    logic [1:0]              addr_nx;
    logic                    en_nx, wr_nx;

    assign any_req = |req_tx;
    assign busy    = (state != IDLE);

    // First set request at or above the pointer, wrapping to zero.
    always_comb begin
        int idx;
        idx   = 0;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_tx[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    always_comb begin
        pick_data  = '0;
        grant_data = '0;
        grant_req  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == IW'(i))
                pick_data = req_tx_data[i*PACKET_WIDTH +: PACKET_WIDTH];
            if (grant == IW'(i)) begin
                grant_data = req_tx_data[i*PACKET_WIDTH +: PACKET_WIDTH];
                grant_req  = req_tx[i];
            end
        end
    end

    always_comb begin
        state_nx    = state;
        start_tx    = 1'b0;
        zero_done   = 1'b0;
        write_done  = 1'b0;
        capture     = 1'b0;
        turn_set_tx = 1'b0;
        turn_set_rx = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_valid && (!turn_tx || !any_req)) begin
                    state_nx = RX_STAT;
                end else if (any_req) begin
                    // An empty packet needs no NIC traffic at all.
                    if (pick_data == '0) begin
                        zero_done = 1'b1;
                    end else begin
                        start_tx = 1'b1;
                        state_nx = TX_STAT;
                    end
                end
            end
            RX_STAT: state_nx = RX_STAT_W;
            RX_STAT_W: begin
                turn_set_tx = 1'b1;
                state_nx = nic_d_out[0] ? RX_READ : IDLE;
            end
            RX_READ: state_nx = RX_READ_W;
            RX_READ_W: begin
                capture     = 1'b1;
                turn_set_tx = 1'b1;
                state_nx    = IDLE;
            end
            TX_STAT: state_nx = TX_STAT_W;
            TX_STAT_W: begin
                turn_set_rx = 1'b1;
                if (!nic_d_out[0] && grant_req) state_nx = TX_WRITE;
                else                            state_nx = IDLE;
            end
            TX_WRITE: begin
                write_done  = 1'b1;
                turn_set_rx = 1'b1;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        adv_ptr  = zero_done | write_done;
        done_idx = zero_done ? pick : grant;
        done_nx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (adv_ptr && done_idx == IW'(i)) done_nx[i] = 1'b1;
        end
        if (done_idx == IW'(NUM_REQ - 1)) ptr_nx = '0;
        else                              ptr_nx = done_idx + IW'(1);
    end

    // Port outputs decoded from the state being entered so they align with it.
    always_comb begin
        en_nx   = 1'b0;
        wr_nx   = 1'b0;
        addr_nx = 2'b00;
        din_nx  = '0;
        unique case (state_nx)
            RX_STAT: begin
                en_nx   = 1'b1;
                addr_nx = 2'b01;
            end
            RX_READ: begin
                en_nx   = 1'b1;
                addr_nx = 2'b00;
            end
            TX_STAT: begin
                en_nx   = 1'b1;
                addr_nx = 2'b11;
            end
            TX_WRITE: begin
                en_nx   = 1'b1;
                wr_nx   = 1'b1;
                addr_nx = 2'b10;
                din_nx  = grant_data;
            end
            default: begin
                en_nx   = 1'b0;
                wr_nx   = 1'b0;
                addr_nx = 2'b00;
                din_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            grant     <= '0;
            turn_tx   <= 1'b0;
            nic_en    <= 1'b0;
            nic_en_wr <= 1'b0;
            nic_addr  <= 2'b00;
            nic_d_in  <= '0;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
            tx_done   <= '0;
        end else begin
            state     <= state_nx;
            nic_en    <= en_nx;
            nic_en_wr <= wr_nx;
            nic_addr  <= addr_nx;
            nic_d_in  <= din_nx;
            tx_done   <= done_nx;
            if (start_tx) grant <= pick;
            if (adv_ptr)  ptr   <= ptr_nx;
            if (turn_set_tx)      turn_tx <= 1'b1;
            else if (turn_set_rx) turn_tx <= 1'b0;
            if (capture) begin
                rx_valid <= 1'b1;
                rx_data  <= nic_d_out;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nic_host_sched.sv
// Random traffic bench for nic_host_sched with a transaction-level
// reference model and a simple registered NIC port model.
module tb_nic_host_sched;

    localparam int W = 64;
    localparam int N = 4;
    localparam int NCYC = 1400;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req_tx = '0;
    logic [N*W-1:0] req_tx_data = '0;
    logic [N-1:0]   tx_done;
    logic           rx_valid;
    logic [W-1:0]   rx_data;
    logic           rx_ready = 1'b0;
    logic [1:0]     nic_addr;
    logic [W-1:0]   nic_d_in;
    logic           nic_en;
    logic           nic_en_wr;
    logic [W-1:0]   nic_d_out = '0;
    logic           busy;

    nic_host_sched #(.PACKET_WIDTH(W), .NUM_REQ(N)) dut (
        .clk(clk), .reset(reset),
        .req_tx(req_tx), .req_tx_data(req_tx_data),
        .tx_done(tx_done),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .nic_addr(nic_addr), .nic_d_in(nic_d_in),
        .nic_en(nic_en), .nic_en_wr(nic_en_wr),
        .nic_d_out(nic_d_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // NIC: read data registered, appears the cycle after the access
    logic         rx_stat = 1'b0;
    logic         tx_stat = 1'b0;
    logic [W-1:0] rx_pkt = '0;
    logic [W-1:0] rnd = '0;

    always @(posedge clk) begin
        if (nic_en && !nic_en_wr) begin
            case (nic_addr)
                2'b00:   nic_d_out <= rx_pkt;
                2'b01:   nic_d_out <= {rnd[W-1:1], rx_stat};
                2'b11:   nic_d_out <= {rnd[W-1:1], tx_stat};
                default: nic_d_out <= rnd;
            endcase
        end else begin
            nic_d_out <= rnd;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs for the current cycle, written by the model
    logic         e_en = 0, e_wr = 0, e_bz = 0, e_rxv = 0;
    logic [1:0]   e_addr = 0;
    logic [W-1:0] e_din = '0, e_rxd = '0;
    logic [N-1:0] e_done = '0;

    int           m_ptr = 0;
    logic         m_turn_tx = 0;
    logic         m_rxv = 0;
    logic [W-1:0] m_rxd = '0;
    logic         abort = 0;

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    // Sets what the next cycle must show, then moves to the next decision point.
    task automatic adv(input logic en, input logic wr, input logic [1:0] a,
                       input logic [W-1:0] d, input logic bz,
                       input logic [N-1:0] dn, input logic cap,
                       input logic [W-1:0] cd);
        if (m_rxv && rx_ready) m_rxv = 1'b0;
        if (cap) begin
            m_rxv = 1'b1;
            m_rxd = cd;
        end
        e_en = en; e_wr = wr; e_addr = a; e_din = d; e_bz = bz;
        e_done = dn; e_rxv = m_rxv; e_rxd = m_rxd;
        @(negedge clk);
        #2;
        if (!reset) abort = 1'b1;
    endtask

    task automatic busy_cyc(input logic en, input logic wr,
                            input logic [1:0] a, input logic [W-1:0] d);
        adv(en, wr, a, d, 1'b1, '0, 1'b0, '0);
    endtask

    task automatic idle_cyc(input logic [N-1:0] dn, input logic cap,
                            input logic [W-1:0] cd);
        adv(1'b0, 1'b0, 2'b00, '0, 1'b0, dn, cap, cd);
    endtask

    task automatic run_txn();
        logic [N-1:0] r, dv;
        logic [W-1:0] gd, cd;
        int g;
        r  = req_tx;
        dv = '0;
        if (!m_rxv && (!m_turn_tx || r == '0)) begin
            busy_cyc(1'b1, 1'b0, 2'b01, '0); if (abort) return;
            busy_cyc(1'b0, 1'b0, 2'b00, '0); if (abort) return;
            m_turn_tx = 1'b1;
            if (nic_d_out[0]) begin
                busy_cyc(1'b1, 1'b0, 2'b00, '0); if (abort) return;
                busy_cyc(1'b0, 1'b0, 2'b00, '0); if (abort) return;
                cd = nic_d_out;
                idle_cyc('0, 1'b1, cd);
            end else begin
                idle_cyc('0, 1'b0, '0);
            end
        end else if (r != '0) begin
            g  = rr_pick(r, m_ptr);
            gd = req_tx_data[g*W +: W];
            dv[g] = 1'b1;
            if (gd == '0) begin
                m_ptr = (g + 1) % N;
                idle_cyc(dv, 1'b0, '0);
                return;
            end
            busy_cyc(1'b1, 1'b0, 2'b11, '0); if (abort) return;
            busy_cyc(1'b0, 1'b0, 2'b00, '0); if (abort) return;
            m_turn_tx = 1'b0;
            if (!nic_d_out[0] && req_tx[g]) begin
                busy_cyc(1'b1, 1'b1, 2'b10, gd); if (abort) return;
                m_ptr = (g + 1) % N;
                idle_cyc(dv, 1'b0, '0);
            end else begin
                idle_cyc('0, 1'b0, '0);
            end
        end else begin
            idle_cyc('0, 1'b0, '0);
        end
    endtask

    initial begin
        forever begin
            if (!reset) begin
                m_ptr = 0; m_turn_tx = 1'b0; m_rxv = 1'b0; m_rxd = '0;
                e_en = 0; e_wr = 0; e_addr = 2'b00; e_din = '0; e_bz = 0;
                e_done = '0; e_rxv = 0; e_rxd = '0;
                @(negedge clk);
                #2;
            end else begin
                abort = 1'b0;
                run_txn();
            end
        end
    end

    // Checker at the falling edge, stimulus 1 time unit later.
    int   drop_pct, raise_pct, zero_pct, rdy_pct, rxs_pct, txs_pct;
    int   rst_cnt = 0;
    logic was_txstat = 1'b0;

    initial begin
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            chk("nic_en", W'(nic_en), W'(e_en));
            chk("nic_en_wr", W'(nic_en_wr), W'(e_wr));
            chk("nic_addr", W'(nic_addr), W'(e_addr));
            chk("nic_d_in", nic_d_in, e_din);
            chk("busy", W'(busy), W'(e_bz));
            chk("tx_done", W'(tx_done), W'(e_done));
            chk("rx_valid", W'(rx_valid), W'(e_rxv));
            chk("rx_data", rx_data, e_rxd);
            #1;
            drop_pct = 3; raise_pct = 20; zero_pct = 15;
            rdy_pct = 70; rxs_pct = 50; txs_pct = 35;
            if (cyc >= 600 && cyc < 800) begin
                drop_pct = 0; raise_pct = 100; zero_pct = 0;
                rdy_pct = 100; rxs_pct = 30; txs_pct = 0;
            end else if (cyc >= 800 && cyc < 1000) begin
                raise_pct = 30; rxs_pct = 100;
                rdy_pct = (cyc < 900) ? 0 : 60;
            end
            if (cyc >= 3 && rst_cnt == 0) begin
                if (cyc < 600 && $urandom_range(199) == 0) rst_cnt = 2;
                if (cyc >= 1000 && was_txstat && $urandom_range(1) == 0)
                    rst_cnt = 2;
            end
            if (cyc < 3) begin
                reset = 1'b0;
            end else if (rst_cnt > 0) begin
                reset = 1'b0;
                rst_cnt--;
            end else begin
                reset = 1'b1;
            end
            was_txstat = nic_en && !nic_en_wr && (nic_addr == 2'b11);
            for (int i = 0; i < N; i++) begin
                if (tx_done[i]) begin
                    req_tx[i] = 1'b0;
                end else if (req_tx[i]) begin
                    if ($urandom_range(99) < drop_pct) req_tx[i] = 1'b0;
                end else if ($urandom_range(99) < raise_pct) begin
                    req_tx[i] = 1'b1;
                    if ($urandom_range(99) < zero_pct)
                        req_tx_data[i*W +: W] = '0;
                    else
                        req_tx_data[i*W +: W] = {$urandom(), $urandom()};
                end
            end
            rx_ready = ($urandom_range(99) < rdy_pct);
            rx_stat  = ($urandom_range(99) < rxs_pct);
            tx_stat  = ($urandom_range(99) < txs_pct);
            rx_pkt   = {$urandom(), $urandom()};
            rnd      = {$urandom(), $urandom()};
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
